// File: rtl/comms_pkg.sv
// Shared definitions for the byte/bit conversion pair of the comms datapath.
// The state encoding is also used by the receiver side and its bench.
package comms_pkg;

    localparam int DATA_SIZE_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/byte_to_bitstream.sv
// Serialises DATA_SIZE-bit words into a 1-bit stream, LSB first, with a one-word
// holding buffer so consecutive words stream without an idle cycle.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | shifter empty, data_out_valid=0, next accept loads shifter
//   ST_SHIFT | shifter loaded, data_out presents bit `count` of the word
module byte_to_bitstream
    import comms_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 word_done
);

    localparam int CNT_W = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_SIZE - 1);

    state_t               state;
    state_t               state_nxt;
    logic [DATA_SIZE-1:0] shifter;
    logic [DATA_SIZE-1:0] shifter_nxt;
    logic [DATA_SIZE-1:0] hold_buf;
    logic [DATA_SIZE-1:0] hold_buf_nxt;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt;
    logic                 hold_full;
    logic                 hold_full_nxt;
    logic                 data_out_nxt;
    logic                 data_out_valid_nxt;
    logic                 word_done_nxt;
    logic                 data_in_ready_nxt;
    logic                 accept;
    logic                 bit_xfer;
    logic                 last_xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            shifter        <= '0;
            hold_buf       <= '0;
            count          <= '0;
            hold_full      <= 1'b0;
            data_out       <= 1'b0;
            data_out_valid <= 1'b0;
            word_done      <= 1'b0;
            data_in_ready  <= 1'b0;
        end else begin
            state          <= state_nxt;
            shifter        <= shifter_nxt;
            hold_buf       <= hold_buf_nxt;
            count          <= count_nxt;
            hold_full      <= hold_full_nxt;
            data_out       <= data_out_nxt;
            data_out_valid <= data_out_valid_nxt;
            word_done      <= word_done_nxt;
            data_in_ready  <= data_in_ready_nxt;
        end
    end

    always_comb begin
        accept    = data_in_valid && data_in_ready;
        bit_xfer  = data_out_valid && data_out_ready;
        last_xfer = bit_xfer && (count == LAST_IDX);

        state_nxt          = state;
        shifter_nxt        = shifter;
        hold_buf_nxt       = hold_buf;
        count_nxt          = count;
        hold_full_nxt      = hold_full;
        data_out_valid_nxt = data_out_valid;
        word_done_nxt      = last_xfer;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shifter_nxt        = data_in;
                    count_nxt          = '0;
                    state_nxt          = ST_SHIFT;
                    data_out_valid_nxt = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_xfer) begin
                    // Held word takes priority; ready is low whenever it is full,
                    // so a bypass accept and a held word never coincide.
                    if (hold_full) begin
                        shifter_nxt   = hold_buf;
                        count_nxt     = '0;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        shifter_nxt = data_in;
                        count_nxt   = '0;
                    end else begin
                        shifter_nxt        = '0;
                        count_nxt          = '0;
                        state_nxt          = ST_IDLE;
                        data_out_valid_nxt = 1'b0;
                    end
                end else begin
                    if (bit_xfer) begin
                        shifter_nxt = shifter >> 1;
                        count_nxt   = count + CNT_W'(1);
                    end
                    if (accept) begin
                        hold_buf_nxt  = data_in;
                        hold_full_nxt = 1'b1;
                    end
                end
            end
        endcase

        // The shifter always presents the current bit at position 0.
        data_out_nxt      = shifter_nxt[0] & data_out_valid_nxt;
        data_in_ready_nxt = ~hold_full_nxt;
    end

endmodule
